tile_board_renderer: RTL

// Pixel-clock pipeline that renders a COLS x ROWS tile board as VGA colour. It sits

---
 rtl/tile_board_renderer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/tile_board_renderer.sv
// tile_board_renderer: pixel-clock pipeline that turns a tile board held in game RAM
// into VGA colour. Cell indexing is done with running counters, a runtime-writable
// palette maps cell codes to colours, and marked rows can flash white.
module tile_board_renderer #(
  parameter int          COLS         = 10,
  parameter int          ROWS         = 20,
  parameter int          CELL_PX      = 20,
  parameter int          ORIGIN_X     = 220,
  parameter int          ORIGIN_Y     = 40,
  parameter int          CODE_W       = 3,
  parameter int          MEM_LAT      = 1,
  parameter logic [11:0] GRID_COLOR   = 12'hFFF,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [9:0]                   x,
  input  logic [8:0]                   y,
  input  logic                         active,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         frame_start,
  output logic [$clog2(COLS*ROWS)-1:0] cell_addr,
  output logic                         cell_rd,
  input  logic [CODE_W-1:0]            cell_data,
  input  logic                         pal_we,
  input  logic [CODE_W-1:0]            pal_idx,
  input  logic [11:0]                  pal_data,
  input  logic [ROWS-1:0]              row_flash,
  output logic [11:0]                  rgb,
  output logic                         hsync_out,
  output logic                         vsync_out
);
  localparam int AW    = $clog2(COLS * ROWS);
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OW    = $clog2(CELL_PX);
  localparam int FW    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int PAL_N = 2 ** CODE_W;

  localparam logic [9:0]    X_LO       = 10'(ORIGIN_X);
  localparam logic [9:0]    X_HI       = 10'(ORIGIN_X + COLS * CELL_PX);
  localparam logic [8:0]    Y_LO       = 9'(ORIGIN_Y);
  localparam logic [8:0]    Y_HI       = 9'(ORIGIN_Y + ROWS * CELL_PX);
  localparam logic [OW-1:0] OFF_LAST   = OW'(CELL_PX - 1);
  localparam logic [AW-1:0] ROW_STEP   = AW'(COLS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);

  function automatic logic [11:0] pal_default(input int idx);
    case (idx)
      1:       return 12'h0FF;
      2:       return 12'hFF0;
      3:       return 12'h4F0;
      4:       return 12'hF00;
      5:       return 12'hA0F;
      6:       return 12'hE80;
      7:       return 12'h02F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] pick_colour(input logic vld, input logic grid,
                                              input logic flash, input logic [11:0] pal_rgb);
    if (!vld)       return 12'h000;
    else if (grid)  return GRID_COLOR;
    else if (flash) return 12'hFFF;
    return pal_rgb;
  endfunction

  logic                x_start, x_in, y_top, y_in;
  logic [OW-1:0]       xoff_q, yoff_q, xoff_c, yoff_c;
  logic [CW-1:0]       col_q, col_c;
  logic [RW-1:0]       row_q, row_c;
  logic [AW-1:0]       base_q, base_c;
  logic                synced_q, synced_c;
  logic                in_board_c, grid_c, flash_c;
  logic                phase_q;
  logic [FW-1:0]       frame_q;
  logic [11:0]         palette [PAL_N];

  logic                vld_p0, grid_p0, flash_p0, hs_p0, vs_p0;
  logic                vld_p   [1:MEM_LAT];
  logic                grid_p  [1:MEM_LAT];
  logic                flash_p [1:MEM_LAT];
  logic                hs_p    [1:MEM_LAT];
  logic                vs_p    [1:MEM_LAT];

  // Counter values for the pixel currently on x/y; a new line restarts the
  // column count, the board top restarts the row count and arms synced.
  always_comb begin
    x_start = (x == X_LO);
    x_in    = (x >= X_LO) && (x < X_HI);
    y_top   = (y == Y_LO);
    y_in    = (y >= Y_LO) && (y < Y_HI);

    if (x_start) begin
      xoff_c = '0;
      col_c  = '0;
    end else if (xoff_q == OFF_LAST) begin
      xoff_c = '0;
      col_c  = col_q + CW'(1);
    end else begin
      xoff_c = xoff_q + OW'(1);
      col_c  = col_q;
    end

    yoff_c = yoff_q;
    row_c  = row_q;
    base_c = base_q;
    if (x_start && y_top) begin
      yoff_c = '0;
      row_c  = '0;
      base_c = '0;
    end else if (x_start && y_in) begin
      if (yoff_q == OFF_LAST) begin
        yoff_c = '0;
        row_c  = row_q + RW'(1);
        base_c = base_q + ROW_STEP;
      end else begin
        yoff_c = yoff_q + OW'(1);
      end
    end

    synced_c   = synced_q | (x_start & y_top);
    in_board_c = synced_c & active & x_in & y_in;
    grid_c     = (xoff_c == '0) | (xoff_c == OFF_LAST) | (yoff_c == '0) | (yoff_c == OFF_LAST);
    flash_c    = phase_q & row_flash[row_c];
  end

  // S0: counters, board read address and per-pixel flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xoff_q    <= '0;
      col_q     <= '0;
      yoff_q    <= '0;
      row_q     <= '0;
      base_q    <= '0;
      synced_q  <= 1'b0;
      cell_addr <= '0;
      vld_p0    <= 1'b0;
      grid_p0   <= 1'b0;
      flash_p0  <= 1'b0;
      hs_p0     <= 1'b1;
      vs_p0     <= 1'b1;
    end else begin
      if (x_in) begin
        xoff_q <= xoff_c;
        col_q  <= col_c;
      end
      if (x_start && y_in) begin
        yoff_q <= yoff_c;
        row_q  <= row_c;
        base_q <= base_c;
      end
      synced_q <= synced_c;
      if (in_board_c) cell_addr <= base_c + AW'(col_c);
      vld_p0   <= in_board_c;
      grid_p0  <= grid_c;
      flash_p0 <= flash_c;
      hs_p0    <= hsync_in;
      vs_p0    <= vsync_in;
    end
  end

  assign cell_rd = vld_p0;

  // S1..S(MEM_LAT): flags ride alongside the board memory read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= MEM_LAT; i++) begin
        vld_p[i]   <= 1'b0;
        grid_p[i]  <= 1'b0;
        flash_p[i] <= 1'b0;
        hs_p[i]    <= 1'b1;
        vs_p[i]    <= 1'b1;
      end
    end else begin
      vld_p[1]   <= vld_p0;
      grid_p[1]  <= grid_p0;
      flash_p[1] <= flash_p0;
      hs_p[1]    <= hs_p0;
      vs_p[1]    <= vs_p0;
      for (int i = 2; i <= MEM_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        grid_p[i]  <= grid_p[i-1];
        flash_p[i] <= flash_p[i-1];
        hs_p[i]    <= hs_p[i-1];
        vs_p[i]    <= vs_p[i-1];
      end
    end
  end

  // Output stage: palette lookup with grid/flash priority, syncs re-aligned
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= pick_colour(vld_p[MEM_LAT], grid_p[MEM_LAT], flash_p[MEM_LAT], palette[cell_data]);
      hsync_out <= hs_p[MEM_LAT];
      vsync_out <= vs_p[MEM_LAT];
    end
  end

  // Palette storage: a same-cycle lookup still sees the old entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PAL_N; i++) palette[i] <= pal_default(i);
    end else if (pal_we) begin
      palette[pal_idx] <= pal_data;
    end
  end

  // Flash phase toggles every FLASH_FRAMES frame_start pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (frame_start) begin
      if (frame_q == FRAME_LAST) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + FW'(1);
      end
    end
  end

endmodule
